// File: rtl/gigatron_rom_loader.sv
// Gigatron program-RAM loader: parses SYNC/ADDR/CNT/DATA[/CSUM] frames from a byte stream.
// Optional checksum byte enabled by defining GIGA_LOADER_CHECKSUM_EN.
module gigatron_rom_loader #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 2500000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] rom_a,
    output logic [15:0] rom_d,
    output logic        rom_we,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_L,
        ST_ADDR_H,
        ST_CNT_L,
        ST_CNT_H,
        ST_DATA_L,
        ST_DATA_H,
        ST_CSUM
    } state_t;

    localparam bit          LP_TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] LP_GAP_MAX = 32'(TIMEOUT) - 32'd1;

    state_t      r_state;
    logic        r_ready;
    logic [15:0] r_addr;
    logic [15:0] r_cnt;
    logic [7:0]  r_lo;
    logic [31:0] r_gap;
    logic [15:0] r_rom_a;
    logic [15:0] r_rom_d;
    logic        r_rom_we;
    logic        r_cpu_rst_n;
    logic        r_done;
    logic        r_err;
`ifdef GIGA_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_xfer;
    logic [15:0] w_cnt_full;

    assign w_xfer     = in_valid & r_ready;
    assign w_cnt_full = {in_data, r_cnt[7:0]};

    // Strobes (rom_we, done) default low each cycle; a gap of TIMEOUT idle cycles aborts the frame.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_addr      <= 16'd0;
            r_cnt       <= 16'd0;
            r_lo        <= 8'd0;
            r_gap       <= 32'd0;
            r_rom_a     <= 16'd0;
            r_rom_d     <= 16'd0;
            r_rom_we    <= 1'b0;
            r_cpu_rst_n <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef GIGA_LOADER_CHECKSUM_EN
            r_sum       <= 8'd0;
`endif
        end else begin
            r_ready  <= 1'b1;
            r_rom_we <= 1'b0;
            r_done   <= 1'b0;
            if (r_state != ST_IDLE && !w_xfer) begin
                if (LP_TO_EN && r_gap == LP_GAP_MAX) begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b1;
                    r_gap   <= 32'd0;
                end else begin
                    r_gap <= r_gap + 32'd1;
                end
            end else if (w_xfer) begin
                r_gap <= 32'd0;
`ifdef GIGA_LOADER_CHECKSUM_EN
                r_sum <= (r_state == ST_IDLE) ? 8'd0 : r_sum + in_data;
`endif
                case (r_state)
                    ST_IDLE: begin
                        if (in_data == SYNC) begin
                            r_state     <= ST_ADDR_L;
                            r_cpu_rst_n <= 1'b0;
                            r_err       <= 1'b0;
                        end
                    end
                    ST_ADDR_L: begin
                        r_addr[7:0] <= in_data;
                        r_state     <= ST_ADDR_H;
                    end
                    ST_ADDR_H: begin
                        r_addr[15:8] <= in_data;
                        r_state      <= ST_CNT_L;
                    end
                    ST_CNT_L: begin
                        r_cnt[7:0] <= in_data;
                        r_state    <= ST_CNT_H;
                    end
                    ST_CNT_H: begin
                        r_cnt <= w_cnt_full;
                        if (w_cnt_full == 16'd0) begin
`ifdef GIGA_LOADER_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state     <= ST_IDLE;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DATA_L;
                        end
                    end
                    ST_DATA_L: begin
                        r_lo    <= in_data;
                        r_state <= ST_DATA_H;
                    end
                    ST_DATA_H: begin
                        r_rom_we <= 1'b1;
                        r_rom_a  <= r_addr;
                        r_rom_d  <= {in_data, r_lo};
                        r_addr   <= r_addr + 16'd1;
                        r_cnt    <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) begin
`ifdef GIGA_LOADER_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state     <= ST_IDLE;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DATA_L;
                        end
                    end
`ifdef GIGA_LOADER_CHECKSUM_EN
                    // A good frame makes all bytes after SYNC, checksum included, sum to zero.
                    ST_CSUM: begin
                        r_state <= ST_IDLE;
                        if (r_sum + in_data == 8'd0) begin
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = r_ready;
    assign rom_a     = r_rom_a;
    assign rom_d     = r_rom_d;
    assign rom_we    = r_rom_we;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_gigatron_rom_loader.sv
// Directed self-checking bench for gigatron_rom_loader (short TIMEOUT for the abort test).
module tb_gigatron_rom_loader;

    localparam int TO = 20;

    logic        clock;
    logic        rstN;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [15:0] romA;
    logic [15:0] romD;
    logic        romWe;
    logic        cpuRstN;
    logic        busy;
    logic        done;
    logic        err;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    logic [15:0] wrAddr[$];
    logic [15:0] wrData[$];

    gigatron_rom_loader #(.SYNC(8'hA5), .TIMEOUT(TO)) dut (
        .clock    (clock),
        .rst_n    (rstN),
        .in_data  (inData),
        .in_valid (inValid),
        .in_ready (inReady),
        .rom_a    (romA),
        .rom_d    (romD),
        .rom_we   (romWe),
        .cpu_rst_n(cpuRstN),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log every write strobe and done pulse, sampled mid-cycle.
    always @(negedge clock) begin
        if (romWe) begin
            wrAddr.push_back(romA);
            wrData.push_back(romD);
        end
        if (done) doneCount++;
    end

    task automatic sendByte(input logic [7:0] b);
        @(negedge clock);
        inData  = b;
        inValid = 1'b1;
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        doneCount = 0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Sends one complete frame and checks SYNC effects, write latency and the finish cycle.
    task automatic loadFrame(input logic [15:0] addr, input int n, input logic [15:0] w [4],
                             input bit badCsum);
        logic [7:0] sum;
        sum = addr[7:0] + addr[15:8] + 8'(n) + 8'(n >> 8);
        sendByte(8'hA5);
        assertCount++;
        if (busy !== 1'b1 || cpuRstN !== 1'b0 || err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sync_effect: busy=%b cpu_rst_n=%b err=%b, need 1 0 0", busy, cpuRstN, err);
        end
        sendByte(addr[7:0]);
        sendByte(addr[15:8]);
        sendByte(8'(n));
        sendByte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            sum = sum + w[i][7:0] + w[i][15:8];
            sendByte(w[i][7:0]);
            sendByte(w[i][15:8]);
            assertCount++;
            if (romWe !== 1'b1 || romA !== addr + 16'(i) || romD !== w[i]) begin
                failCount++;
                $display("[TB] FAIL write_latency[%0d]: we=%b a=%h d=%h, need 1 %h %h",
                         i, romWe, romA, romD, addr + 16'(i), w[i]);
            end
        end
`ifdef GIGA_LOADER_CHECKSUM_EN
        sendByte(badCsum ? 8'h01 - sum : 8'h00 - sum);
`endif
        assertCount++;
        if (badCsum) begin
            if (done !== 1'b0 || cpuRstN !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL bad_csum_end: done=%b cpu_rst_n=%b err=%b busy=%b, need 0 0 1 0",
                         done, cpuRstN, err, busy);
            end
        end else if (done !== 1'b1 || cpuRstN !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL frame_end: done=%b cpu_rst_n=%b busy=%b err=%b, need 1 1 0 0",
                     done, cpuRstN, busy, err);
        end
        idleCycles(2);
    endtask

    task automatic checkLog(input string name, input int n, input logic [15:0] a [4],
                            input logic [15:0] d [4], input int expDone);
        assertCount++;
        if (wrAddr.size() != n || doneCount != expDone) begin
            failCount++;
            $display("[TB] FAIL %s_counts: writes=%0d done=%0d, need %0d %0d",
                     name, wrAddr.size(), doneCount, n, expDone);
        end else begin
            for (int i = 0; i < n; i++) begin
                assertCount++;
                if (wrAddr[i] !== a[i] || wrData[i] !== d[i]) begin
                    failCount++;
                    $display("[TB] FAIL %s_word[%0d]: %h=%h, need %h=%h",
                             name, i, wrAddr[i], wrData[i], a[i], d[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; inData = 8'h00; inValid = 1'b0;
        #17;
        assertCount++;
        if ({inReady, romA, romD, romWe, cpuRstN, busy, done, err} !== {1'b0, 16'h0, 16'h0, 5'b01000}) begin
            failCount++;
            $display("[TB] FAIL reset_values: ready=%b a=%h d=%h we=%b cpu=%b busy=%b done=%b err=%b",
                     inReady, romA, romD, romWe, cpuRstN, busy, done, err);
        end
        @(negedge clock);
        rstN = 1'b1;
        @(posedge clock);
        #1;
        assertCount++;
        if (inReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ready_after_reset: got %b, need 1", inReady);
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] w [4] = '{16'h1234, 16'h5678, 16'h0, 16'h0};
        logic [15:0] a [4] = '{16'h0100, 16'h0101, 16'h0, 16'h0};
        clearLog();
        loadFrame(16'h0100, 2, w, 1'b0);
        checkLog("basic", 2, a, w, 1);
    endtask

    task automatic test_idle_ignore();
        logic [15:0] w [4] = '{16'hABCD, 16'hA5A5, 16'h0, 16'h0};
        logic [15:0] a [4] = '{16'h0200, 16'h0201, 16'h0, 16'h0};
        clearLog();
        sendByte(8'h00);
        sendByte(8'hFF);
        assertCount++;
        if (busy !== 1'b0 || cpuRstN !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL idle_ignore: busy=%b cpu_rst_n=%b, need 0 1", busy, cpuRstN);
        end
        loadFrame(16'h0200, 2, w, 1'b0);
        checkLog("idle_then_load", 2, a, w, 1);
    endtask

    task automatic test_wrap();
        logic [15:0] w [4] = '{16'h1111, 16'h2222, 16'h0, 16'h0};
        logic [15:0] a [4] = '{16'hFFFF, 16'h0000, 16'h0, 16'h0};
        clearLog();
        loadFrame(16'hFFFF, 2, w, 1'b0);
        checkLog("wrap", 2, a, w, 1);
    endtask

    task automatic test_zero_count();
        logic [15:0] w [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
        clearLog();
        loadFrame(16'h0400, 0, w, 1'b0);
        checkLog("zero_count", 0, w, w, 1);
    endtask

    task automatic test_timeout();
        logic [15:0] w [4] = '{16'hBEEF, 16'h0, 16'h0, 16'h0};
        logic [15:0] a [4] = '{16'h0300, 16'h0, 16'h0, 16'h0};
        clearLog();
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h01);
        idleCycles(TO + 5);
        assertCount++;
        if (err !== 1'b1 || busy !== 1'b0 || cpuRstN !== 1'b0 || wrAddr.size() != 0 || doneCount != 0) begin
            failCount++;
            $display("[TB] FAIL timeout_abort: err=%b busy=%b cpu_rst_n=%b writes=%0d done=%0d, need 1 0 0 0 0",
                     err, busy, cpuRstN, wrAddr.size(), doneCount);
        end
        sendByte(8'h00);
        assertCount++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL err_sticky: err=%b busy=%b, need 1 0", err, busy);
        end
        loadFrame(16'h0300, 1, w, 1'b0);
        checkLog("after_timeout", 1, a, w, 1);
    endtask

    task automatic test_bad_checksum();
`ifdef GIGA_LOADER_CHECKSUM_EN
        logic [15:0] w [4] = '{16'h1234, 16'h5678, 16'h0, 16'h0};
        logic [15:0] a [4] = '{16'h0100, 16'h0101, 16'h0, 16'h0};
        clearLog();
        loadFrame(16'h0100, 2, w, 1'b1);
        checkLog("bad_csum", 2, a, w, 0);
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w [4] = '{16'hCAFE, 16'h0, 16'h0, 16'h0};
        logic [15:0] a [4] = '{16'h0500, 16'h0, 16'h0, 16'h0};
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h34);
        #2;
        rstN = 1'b0;
        #1;
        assertCount++;
        if ({inReady, romA, romD, romWe, cpuRstN, busy, done, err} !== {1'b0, 16'h0, 16'h0, 5'b01000}) begin
            failCount++;
            $display("[TB] FAIL reset_mid_frame: ready=%b a=%h d=%h we=%b cpu=%b busy=%b done=%b err=%b",
                     inReady, romA, romD, romWe, cpuRstN, busy, done, err);
        end
        @(negedge clock);
        rstN = 1'b1;
        idleCycles(1);
        clearLog();
        loadFrame(16'h0500, 1, w, 1'b0);
        checkLog("after_reset", 1, a, w, 1);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_idle_ignore();
        test_wrap();
        test_zero_count();
        test_timeout();
        test_bad_checksum();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
